// File: rtl/crosspoint_matrix.sv
// N_IN x N_OUT crosspoint switch with a serially loaded shadow route table, committed atomically; optional readback via CROSSPOINT_READBACK_EN.
// Latency: committed routes drive outs the cycle after the last COMMIT bit; inp->outs is purely combinational.
// Backpressure: none; every frame is accepted or counted as rejected, and dat_valid=0 cycles simply pause the shifter.
module crosspoint_matrix #(
  parameter int N_IN  = 48,
  parameter int N_OUT = 48,
  parameter int ERR_W = 8
) (
  input  logic              clk_,
  input  logic              clear_n,
  input  logic              dat,
  input  logic              dat_valid,
  input  logic [N_IN-1:0]   inp,
  output logic [N_OUT-1:0]  outs,
  output logic              pending,
  output logic [ERR_W-1:0]  err_cnt
`ifdef CROSSPOINT_READBACK_EN
  ,
  output logic              dout
`endif
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int F  = 3 + OW + IW;
  localparam int CW = $clog2(F);

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_ROUTE     = 3'd1,
    OP_SET1      = 3'd2,
    OP_CLR1      = 3'd3,
    OP_COMMIT    = 3'd4,
    OP_CLEAR_ALL = 3'd5,
    OP_READ      = 3'd6,
    OP_RSVD      = 3'd7
  } op_t;

  logic [F-2:0]               shift_reg;
  logic [CW-1:0]              bit_cnt;
  logic [N_OUT-1:0][IW-1:0]   shd_src;
  logic [N_OUT-1:0][IW-1:0]   act_src;
  logic [N_OUT-1:0]           shd_const;
  logic [N_OUT-1:0]           act_const;

  logic [F-1:0]               frame;
  op_t                        op;
  logic [OW-1:0]              oidx;
  logic [IW-1:0]              arg;
  logic                       frame_done;
  logic                       oidx_ok;
  logic                       arg_ok;
  logic                       reject;
  logic [2**IW-1:0]           inp_ext;

  always_comb begin
    frame      = {shift_reg, dat};
    op         = op_t'(frame[F-1 -: 3]);
    oidx       = frame[IW +: OW];
    arg        = frame[IW-1:0];
    frame_done = dat_valid && (bit_cnt == CW'(F - 1));
    oidx_ok    = {1'b0, oidx} < (OW+1)'(N_OUT);
    arg_ok     = arg <= IW'(N_IN);
    reject     = 1'b0;
    case (op)
      OP_ROUTE:         reject = !oidx_ok || !arg_ok;
      OP_SET1, OP_CLR1: reject = !oidx_ok;
`ifdef CROSSPOINT_READBACK_EN
      OP_READ:          reject = !oidx_ok;
`else
      OP_READ:          reject = 1'b1;
`endif
      OP_RSVD:          reject = 1'b1;
      default:          reject = 1'b0;
    endcase
  end

  // Slot 0 of the extended input vector is tied low so src=0 means disconnected.
  always_comb begin
    inp_ext = (2**IW)'({inp, 1'b0});
    outs    = '0;
    if (clear_n) begin
      for (int o = 0; o < N_OUT; o++) begin
        outs[o] = act_const[o] | inp_ext[act_src[o]];
      end
    end
  end

  always_ff @(posedge clk_) begin
    if (!clear_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      shd_src   <= '0;
      act_src   <= '0;
      shd_const <= '0;
      act_const <= '0;
      pending   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (dat_valid) begin
        if (frame_done) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt   <= bit_cnt + 1'b1;
          shift_reg <= {shift_reg[F-3:0], dat};
        end
      end
      if (frame_done) begin
        if (reject) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end else begin
          case (op)
            OP_ROUTE:     shd_src[oidx]   <= arg;
            OP_SET1:      shd_const[oidx] <= 1'b1;
            OP_CLR1:      shd_const[oidx] <= 1'b0;
            OP_COMMIT: begin
              act_src   <= shd_src;
              act_const <= shd_const;
            end
            OP_CLEAR_ALL: begin
              shd_src   <= '0;
              shd_const <= '0;
            end
            default: ;
          endcase
        end
      end
      pending <= (shd_src != act_src) || (shd_const != act_const);
    end
  end

`ifdef CROSSPOINT_READBACK_EN
  logic [IW:0] rb_sr;

  // Readback drains while the next frame shifts in, one bit per dat_valid cycle.
  always_ff @(posedge clk_) begin
    if (!clear_n) begin
      rb_sr <= '0;
    end else if (frame_done && !reject && op == OP_READ) begin
      rb_sr <= {act_const[oidx], act_src[oidx]};
    end else if (dat_valid) begin
      rb_sr <= {rb_sr[IW-1:0], 1'b0};
    end
  end

  assign dout = clear_n & rb_sr[IW];
`endif

endmodule
